// File: rtl/imm_gen_pkg.sv
// Shared types and opcode match constants for the LEGv8 immediate generator.
package imm_gen_pkg;

  // Immediate format reported alongside the extended value.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_D    = 3'd1,
    FMT_I    = 3'd2,
    FMT_CB   = 3'd3,
    FMT_B    = 3'd4,
    FMT_IM   = 3'd5
  } fmt_e;

  // Occupancy of the two-entry output skid buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Opcode fields, each compared against its own slice of the instruction.
  localparam logic [10:0] OP_STUR = 11'b11111000000;  // instr[31:21]
  localparam logic [10:0] OP_LDUR = 11'b11111000010;  // instr[31:21]
  localparam logic [6:0]  OP_I    = 7'b1000100;       // instr[28:22], instr[31]=1
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;      // instr[31:24]
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;      // instr[31:24]
  localparam logic [5:0]  OP_B    = 6'b000101;        // instr[31:26]
  localparam logic [5:0]  OP_BL   = 6'b100101;        // instr[31:26]
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;     // instr[31:23]
  localparam logic [8:0]  OP_MOVK = 9'b111100101;     // instr[31:23]

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational LEGv8 immediate decoder: format match plus sign/zero extension.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int BR_SHIFT = 1
) (
  input  logic [31:0]              instr,
  output logic signed [DATA_W-1:0] imm,
  output fmt_e                     fmt,
  output logic                     illegal
);

  localparam int BR_AMT = (BR_SHIFT != 0) ? 2 : 0;

  // Formats are disjoint; anything unmatched (or a MOVZ/MOVK shift past the
  // datapath width) is reported as illegal with a zero immediate.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      fmt = FMT_D;
      imm = {{(DATA_W-9){instr[20]}}, instr[20:12]};
    end else if (instr[31] && instr[28:22] == OP_I) begin
      fmt = FMT_I;
      imm = {{(DATA_W-12){1'b0}}, instr[21:10]};
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
      fmt = FMT_CB;
      imm = {{(DATA_W-19){instr[23]}}, instr[23:5]} << BR_AMT;
    end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      fmt = FMT_B;
      imm = {{(DATA_W-26){instr[25]}}, instr[25:0]} << BR_AMT;
    end else if (instr[31:23] == OP_MOVZ || instr[31:23] == OP_MOVK) begin
      if (DATA_W == 32 && instr[22]) begin
        illegal = 1'b1;
      end else begin
        fmt = FMT_IM;
        imm = {{(DATA_W-16){1'b0}}, instr[20:5]} << {instr[22:21], 4'b0000};
      end
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decode on the input side, two-entry skid buffer on the
// output side, plus a saturating count of illegal results delivered.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int BR_SHIFT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_imm,
  output logic [2:0]               out_fmt,
  output logic                     out_illegal,
  output logic [CNT_W-1:0]         illegal_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic signed [DATA_W-1:0] dec_imm_p0;
  fmt_e                     dec_fmt_p0;
  logic                     dec_ill_p0;

  logic signed [DATA_W-1:0] skid_imm_p1;
  fmt_e                     skid_fmt_p1;
  logic                     skid_ill_p1;

  buf_state_e state, state_nxt;
  logic       in_xfer, out_xfer;
  logic       load_head_dec, load_head_skid, load_skid;

  imm_decode #(
    .DATA_W  (DATA_W),
    .BR_SHIFT(BR_SHIFT)
  ) u_decode (
    .instr  (in_instr),
    .imm    (dec_imm_p0),
    .fmt    (dec_fmt_p0),
    .illegal(dec_ill_p0)
  );

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Buffer occupancy next-state and which register loads on this edge.
  always_comb begin
    state_nxt      = state;
    load_head_dec  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (in_xfer) begin
          state_nxt     = BUF_ONE;
          load_head_dec = 1'b1;
        end
      end
      BUF_ONE: begin
        if (in_xfer && out_xfer) begin
          load_head_dec = 1'b1;
        end else if (in_xfer) begin
          state_nxt = BUF_TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (out_xfer) begin
          state_nxt      = BUF_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_nxt = BUF_EMPTY;
    endcase
  end

  // State register; handshake flags registered from next state so in_ready
  // has no combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BUF_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != BUF_TWO);
      out_valid <= (state_nxt != BUF_EMPTY);
    end
  end

  // ---- stage p0 -> p1: skid entry captures a word arriving while head stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_imm_p1 <= '0;
      skid_fmt_p1 <= FMT_NONE;
      skid_ill_p1 <= 1'b0;
    end else if (load_skid) begin
      skid_imm_p1 <= dec_imm_p0;
      skid_fmt_p1 <= dec_fmt_p0;
      skid_ill_p1 <= dec_ill_p0;
    end
  end

  // ---- stage p1 -> output head: load from decoder or promote the skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm     <= '0;
      out_fmt     <= FMT_NONE;
      out_illegal <= 1'b0;
    end else if (load_head_dec) begin
      out_imm     <= dec_imm_p0;
      out_fmt     <= dec_fmt_p0;
      out_illegal <= dec_ill_p0;
    end else if (load_head_skid) begin
      out_imm     <= skid_imm_p1;
      out_fmt     <= skid_fmt_p1;
      out_illegal <= skid_ill_p1;
    end
  end

  // Count illegal results as they leave, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (out_xfer && out_illegal) begin
      illegal_cnt <= sat_inc(illegal_cnt);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 64-bit and a 32-bit instance run in
// lockstep on the same stimulus; expected results queue up at input accept.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;

  logic        in_ready_a, out_valid_a, out_ill_a;
  logic [63:0] out_imm_a;
  logic [2:0]  out_fmt_a;
  logic [3:0]  cnt_a;

  logic        in_ready_b, out_valid_b, out_ill_b;
  logic [31:0] out_imm_b;
  logic [2:0]  out_fmt_b;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  imm_gen_pipe #(.DATA_W(64), .BR_SHIFT(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_ill_a),
    .illegal_cnt(cnt_a)
  );

  imm_gen_pipe #(.DATA_W(32), .BR_SHIFT(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_ill_b),
    .illegal_cnt(cnt_b)
  );

  typedef struct {
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
  } exp_t;

  exp_t        q[$];
  exp_t        cur_exp;
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  cnt64_m, cnt32_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] i64, input logic [2:0] f64, input logic l64,
                              input logic [31:0] i32, input logic [2:0] f32, input logic l32);
    exp_t e;
    e.imm64 = i64; e.fmt64 = f64; e.ill64 = l64;
    e.imm32 = i32; e.fmt32 = f32; e.ill32 = l32;
    return e;
  endfunction

  // Reference decode written with signed casts and multiplies.
  function automatic exp_t model(input logic [31:0] w);
    exp_t        e;
    longint      v;
    logic [63:0] u;
    logic [2:0]  f;
    logic        im_wide;
    v = 0; f = 3'd0; im_wide = 1'b0;
    if (w[31:21] == 11'b11111000000 || w[31:21] == 11'b11111000010) begin
      f = 3'd1; v = longint'($signed(w[20:12]));
    end else if (w[31] == 1'b1 && w[28:22] == 7'b1000100) begin
      f = 3'd2; v = longint'({52'd0, w[21:10]});
    end else if (w[31:25] == 7'b1011010) begin
      f = 3'd3; v = longint'($signed(w[23:5])) * 4;
    end else if (w[30:26] == 5'b00101 && !(w[31:26] == 6'b000101 && 1'b0)) begin
      f = 3'd4; v = longint'($signed(w[25:0])) * 4;
    end else if (w[31:23] == 9'b110100101 || w[31:23] == 9'b111100101) begin
      f = 3'd5; v = longint'({48'd0, w[20:5]}) << (16 * w[22:21]); im_wide = w[22];
    end
    u = v;
    e.fmt64 = f;
    e.ill64 = (f == 3'd0);
    e.imm64 = e.ill64 ? 64'd0 : u;
    if (e.ill64 || im_wide) begin
      e.fmt32 = 3'd0; e.ill32 = 1'b1; e.imm32 = 32'd0;
    end else begin
      e.fmt32 = f; e.ill32 = 1'b0; e.imm32 = u[31:0];
    end
    return e;
  endfunction

  task automatic drive(input logic [31:0] w);
    in_instr = w;
    cur_exp  = model(w);
  endtask

  // One clock: check outputs against the queue head, account transfers,
  // advance to the next falling edge, then check the counters.
  task automatic tick(output bit infire);
    bit   outfire;
    exp_t e;
    chk("in_ready_a", 64'(in_ready_a), 64'(q.size() < 2));
    chk("in_ready_b", 64'(in_ready_b), 64'(q.size() < 2));
    chk("out_valid_a", 64'(out_valid_a), 64'(q.size() != 0));
    chk("out_valid_b", 64'(out_valid_b), 64'(q.size() != 0));
    if (q.size() != 0) begin
      e = q[0];
      chk("imm64", out_imm_a, e.imm64);
      chk("fmt64", 64'(out_fmt_a), 64'(e.fmt64));
      chk("ill64", 64'(out_ill_a), 64'(e.ill64));
      chk("imm32", 64'(out_imm_b), 64'(e.imm32));
      chk("fmt32", 64'(out_fmt_b), 64'(e.fmt32));
      chk("ill32", 64'(out_ill_b), 64'(e.ill32));
    end
    outfire = (q.size() != 0) && out_ready;
    infire  = in_valid && (q.size() < 2);
    if (outfire) begin
      e = q.pop_front();
      if (e.ill64 && cnt64_m != 4'hF) cnt64_m = cnt64_m + 4'd1;
      if (e.ill32 && cnt32_m != 4'hF) cnt32_m = cnt32_m + 4'd1;
    end
    if (infire) q.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
    chk("cnt64", 64'(cnt_a), 64'(cnt64_m));
    chk("cnt32", 64'(cnt_b), 64'(cnt32_m));
  endtask

  task automatic send_exp(input logic [31:0] w, input exp_t e);
    bit f;
    f = 1'b0;
    in_instr = w;
    cur_exp  = e;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !f; i++) tick(f);
    in_valid = 1'b0;
    if (!f) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [31:0] w);
    send_exp(w, model(w));
  endtask

  task automatic drain();
    bit f;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick(f);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  logic [31:0] tbl [0:9];
  initial begin
    tbl[0] = {11'b11111000010, 9'h1FF, 2'b00, 5'd1, 5'd2};   // LDUR -1
    tbl[1] = {11'b11111000000, 9'h0FF, 2'b00, 5'd3, 5'd4};   // STUR +255
    tbl[2] = {10'b1001000100, 12'hABC, 5'd1, 5'd2};          // ADDI
    tbl[3] = {10'b1101000100, 12'hFFF, 5'd7, 5'd8};          // SUBI
    tbl[4] = {8'hB5, 19'h00003, 5'd9};                       // CBNZ +3
    tbl[5] = {6'b000101, 26'h2000000};                       // B most negative
    tbl[6] = {6'b100101, 26'h0000010};                       // BL +16
    tbl[7] = {9'b111100101, 2'b01, 16'h1234, 5'd0};          // MOVK hw=1
    tbl[8] = {9'b110100101, 2'b11, 16'hCAFE, 5'd0};          // MOVZ hw=3
    tbl[9] = 32'h0000_0000;                                  // illegal
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   f;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'd0;
    cnt64_m = 4'd0; cnt32_m = 4'd0;
    cur_exp = model(32'd0);
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready", 64'(in_ready_a), 64'd1);
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_imm", out_imm_a, 64'd0);
    chk("rst_fmt", 64'(out_fmt_a), 64'd0);
    chk("rst_ill", 64'(out_ill_a), 64'd0);
    chk("rst_cnt", 64'(cnt_a), 64'd0);
    chk("rst_out_valid_b", 64'(out_valid_b), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with known constants
    out_ready = 1'b1;
    send_exp({11'b11111000010, 9'h1FF, 2'b00, 5'd1, 5'd2},
             mk(64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 32'hFFFF_FFFF, 3'd1, 1'b0));
    send_exp({8'hB4, 19'h40000, 5'd3},
             mk(64'hFFFF_FFFF_FFF0_0000, 3'd3, 1'b0, 32'hFFF0_0000, 3'd3, 1'b0));
    send_exp({9'b110100101, 2'b10, 16'hBEEF, 5'd0},
             mk(64'h0000_BEEF_0000_0000, 3'd5, 1'b0, 32'd0, 3'd0, 1'b1));
    send_exp({6'b000101, 26'h2000000},
             mk(64'hFFFF_FFFF_F800_0000, 3'd4, 1'b0, 32'hF800_0000, 3'd4, 1'b0));
    send_exp({10'b1001000100, 12'hABC, 5'd1, 5'd2},
             mk(64'h0000_0000_0000_0ABC, 3'd2, 1'b0, 32'h0000_0ABC, 3'd2, 1'b0));
    send_exp(32'h0000_0000, mk(64'd0, 3'd0, 1'b1, 32'd0, 3'd0, 1'b1));

    // Back-to-back table at full throughput
    for (int i = 0; i < 10; i++) send(tbl[i]);
    drain();

    // Stall with three words: two accepted, third waits for out_ready
    out_ready = 1'b0;
    send(tbl[2]);
    send(tbl[4]);
    chk("stall_in_ready", 64'(in_ready_a), 64'd0);
    in_valid = 1'b1;
    drive(tbl[7]);
    tick(f);
    chk("stall_no_accept", 64'(f), 64'd0);
    tick(f);
    out_ready = 1'b1;
    send(tbl[7]);
    drain();

    // Random handshakes
    for (int i = 0; i < 120; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) drive($urandom);
      else drive(tbl[$urandom_range(0, 9)]);
      tick(f);
    end
    drain();

    // Counter saturation: 2^4 + 5 illegal words
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) send(32'h0000_0000);
    drain();
    chk("sat_cnt64", 64'(cnt_a), 64'hF);
    chk("sat_cnt32", 64'(cnt_b), 64'hF);

    // Reset while holding two words
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[1]);
    chk("two_in_ready", 64'(in_ready_a), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid_a), 64'd0);
    chk("arst_in_ready", 64'(in_ready_a), 64'd1);
    chk("arst_out_valid_b", 64'(out_valid_b), 64'd0);
    chk("arst_cnt", 64'(cnt_a), 64'd0);
    q.delete();
    cnt64_m = 4'd0; cnt32_m = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick(f);
    send(tbl[6]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter DATA_W, default 64: immediate output width; legal values 32 or 64.
REQ-002 Parameter BR_SHIFT, default 1: when 1, CB/B offsets are shifted left 2 (byte offsets); when 0, unshifted word offsets.
REQ-003 Parameter CNT_W, default 16: width of the illegal-instruction counter.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  instruction word present.
REQ-007 in_ready  out  1  block can accept; registered.
REQ-008 in_instr  in  32  LEGv8 instruction word.
REQ-009 out_valid  out  1  result present.
REQ-010 out_ready  in  1  downstream accepts result.
REQ-011 out_imm  out  DATA_W  extended immediate.
REQ-012 out_fmt  out  3  format code: 0 NONE, 1 D, 2 I, 3 CB, 4 B, 5 IM.
REQ-013 out_illegal  out  1  no format matched, or IM shift exceeds DATA_W.
REQ-014 illegal_cnt  out  CNT_W  saturating count of illegal results delivered.

Function
REQ-015 Decode (disjoint): D when instr[31:21] = 11111000000 or 11111000010; I when instr[31]=1 and instr[28:22] = 1000100; CB when instr[31:24] = 10110100 or 10110101; B when instr[31:26] = 000101 or 100101; IM when instr[31:23] = 110100101 or 111100101.
REQ-016 D: sign-extend instr[20:12] to DATA_W.
REQ-017 I: zero-extend instr[21:10] to DATA_W.
REQ-018 CB: sign-extend instr[23:5], then shift left 2 if BR_SHIFT=1.
REQ-019 B: sign-extend instr[25:0], then shift left 2 if BR_SHIFT=1.
REQ-020 IM: zero-extend instr[20:5], shifted left by 16*instr[22:21]; if DATA_W=32 and instr[22]=1, result is illegal.
REQ-021 Illegal results: out_imm = 0, out_fmt = 0 (NONE), out_illegal = 1; the result is still delivered through the handshake.
REQ-022 A transfer occurs on a cycle when valid and ready are both high; this applies separately to the input and output sides.
REQ-023 Latency: a word accepted at edge N is visible on the outputs after edge N; this is 1 cycle when the buffer is empty. Throughput is 1 word/cycle while out_ready=1.
REQ-024 Buffering: a 2-entry skid buffer with states EMPTY, ONE, TWO.
- EMPTY to ONE on input transfer.
- ONE to TWO on input transfer without output transfer.
- ONE to EMPTY on output transfer without input transfer.
- TWO to ONE on output transfer.
- All other combinations hold state.
REQ-025 in_ready = 1 in EMPTY and ONE, and 0 in TWO; it is a registered value, so there is no combinational path from out_ready to in_ready.
REQ-026 Ordering is strictly FIFO; no result is ever dropped or duplicated.
REQ-027 While out_valid=1 and out_ready=0, out_imm, out_fmt and out_illegal are held stable.
REQ-028 In ONE, a simultaneous input and output transfer keeps the state at ONE and presents the new word on the next cycle.
REQ-029 illegal_cnt increments by 1 on each output transfer with out_illegal=1 and saturates at all-ones (no wrap).

Reset
REQ-030 While rst_n=0:
- state = EMPTY, in_ready = 1, out_valid = 0;
- out_imm = 0, out_fmt = 0, out_illegal = 0, illegal_cnt = 0.
REQ-031 Reset asserted mid-transfer discards all buffered words; the first cycle after release behaves as EMPTY.

Structure
REQ-032 Shared package imm_gen_pkg holds:
- the format enum (NONE/D/I/CB/B/IM);
- the opcode match constants;
- the buffer state enum.
REQ-033 One combinational sub-module, imm_decode, maps in_instr to (imm, fmt, illegal) and is parametrised by DATA_W and BR_SHIFT.
REQ-034 imm_gen_pipe instantiates imm_decode on the input side and registers its results into the skid buffer.

Verification
REQ-035 Send LDUR with imm9 = 0x1FF, out_ready=1 -> next cycle out_imm = 0xFFFF_FFFF_FFFF_FFFF, out_fmt = 1.
REQ-036 Send CBZ with imm19 = 0x40000, BR_SHIFT=1 -> out_imm = 0xFFFF_FFFF_FFF0_0000, out_fmt = 3.
REQ-037 Send MOVZ with hw=2, imm16=0xBEEF -> out_imm = 0x0000_BEEF_0000_0000 (DATA_W=64); with DATA_W=32 -> out_imm = 0, out_illegal = 1.
REQ-038 Hold in_valid=1 with 3 distinct words and out_ready=0 for 3 cycles -> 2 accepted, in_ready = 0 on cycle 3; then out_ready=1 -> all 3 words emerge in order with no loss.
REQ-039 Deliver 2^CNT_W + 5 illegal words (0x0000_0000) -> illegal_cnt stops at all-ones.
REQ-040 Assert rst_n=0 while in state TWO -> out_valid = 0 and in_ready = 1 immediately; no stale word appears after release.
